// File: rtl/mem_arbiter_if.sv
// Request/grant and memory bus bundle shared by the fetch port,
// the load/store port and the single-port memory behind mem_arbiter.
interface mem_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 16
);
   logic          if_req;
   logic [AW-1:0] if_adr;
   logic          if_gnt;
   logic [DW-1:0] if_rdata;
   logic          if_rvalid;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_adr;
   logic [DW-1:0] d_wd;
   logic          d_gnt;
   logic [DW-1:0] d_rdata;
   logic          d_rvalid;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wd;
   logic          mem_we;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  if_req, if_adr,
      input  d_req, d_we, d_adr, d_wd,
      input  mem_rd,
      output if_gnt, if_rdata, if_rvalid,
      output d_gnt, d_rdata, d_rvalid,
      output mem_adr, mem_wd, mem_we
   );

   modport master (
      output if_req, if_adr,
      output d_req, d_we, d_adr, d_wd,
      output mem_rd,
      input  if_gnt, if_rdata, if_rvalid,
      input  d_gnt, d_rdata, d_rvalid,
      input  mem_adr, mem_wd, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between
// instruction fetch and load/store, with registered read return.
module mem_arbiter #(
   parameter int AW = 5,
   parameter int DW = 16
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   logic          if_gnt;
   logic          d_gnt;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wd;
   logic          mem_we;

   logic          last_q, last_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          if_rvalid_q, if_rvalid_d;
   logic          d_rvalid_q, d_rvalid_d;

   // On a tie the port that did not win last time gets the memory.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (rst) begin
         if_gnt = 1'b0;
         d_gnt  = 1'b0;
      end else if (bus.if_req && bus.d_req) begin
         if_gnt = last_q;
         d_gnt  = !last_q;
      end else if (bus.if_req) begin
         if_gnt = 1'b1;
      end else if (bus.d_req) begin
         d_gnt = 1'b1;
      end
   end

   always_comb begin
      mem_adr = '0;
      mem_wd  = '0;
      mem_we  = 1'b0;
      if (if_gnt) begin
         mem_adr = bus.if_adr;
      end else if (d_gnt) begin
         mem_adr = bus.d_adr;
         mem_wd  = bus.d_wd;
         mem_we  = bus.d_we;
      end
   end

   always_comb begin
      last_d      = last_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_rvalid_d = if_gnt;
      d_rvalid_d  = d_gnt && !bus.d_we;
      if (if_gnt) begin
         last_d     = 1'b0;
         if_rdata_d = bus.mem_rd;
      end
      if (d_gnt) begin
         last_d = 1'b1;
         if (!bus.d_we) begin
            d_rdata_d = bus.mem_rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= 1'b1;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
      end else begin
         last_q      <= last_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.mem_adr   = mem_adr;
   assign bus.mem_wd    = mem_wd;
   assign bus.mem_we    = mem_we;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_rvalid  = d_rvalid_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 32x16 `Memory` between the instruction-fetch path and the load/store path of the core. Each cycle it grants at most one requester and drives the memory address, write data and write enable from that requester. Read data is captured into a per-port register and returned one cycle later with a valid strobe. Ties are resolved round-robin, so neither port can starve the other.

## Interface
- `AW`, default 5, address width (32 words).
- `DW`, default 16, data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch port requests a read.
- `if_adr`  in  AW  fetch read address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rdata`  out  DW  fetch read data, valid when `if_rvalid`.
- `if_rvalid`  out  1  one-cycle strobe, `if_rdata` holds the result of the previous granted fetch.
- `d_req`  in  1  data port requests an access.
- `d_we`  in  1  1 = write, 0 = read.
- `d_adr`  in  AW  data access address.
- `d_wd`  in  DW  data write value.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rdata`  out  DW  data read result, valid when `d_rvalid`.
- `d_rvalid`  out  1  one-cycle strobe for a granted data read; never asserted for writes.
- `mem_adr`  out  AW  to `Memory.adr`.
- `mem_wd`  out  DW  to `Memory.WD`.
- `mem_we`  out  1  to `Memory.WE`.
- `mem_rd`  in  DW  from `Memory.Memout`. This is the combinational read of `mem_adr`.

## Operation
- State: `last` (1 bit, 0 = fetch granted last, 1 = data granted last), `if_rdata`, `d_rdata`, `if_rvalid`, `d_rvalid`.
- Grant logic is combinational from the requests and `last`:
  - Only `if_req` is high: fetch is granted.
  - Only `d_req` is high: data is granted.
  - Both are high: the port not named by `last` is granted.
  - Neither is high: no grant.
- `if_gnt` and `d_gnt` are never both 1.
- Memory drive:
  - Granted port's address goes to `mem_adr`.
  - `mem_we` = `d_gnt & d_we`.
  - `mem_wd` = `d_wd` when data is granted, else 0.
  - With no grant: `mem_adr` = 0, `mem_wd` = 0, `mem_we` = 0.
- At each rising edge with a grant:
  - `last` is updated to the granted port.
  - For a read, `mem_rd` is registered into that port's rdata register and that port's rvalid is set.
  - For a write, the memory updates and no rvalid is set.
- rvalid is set for exactly one cycle per granted read. The rdata register holds its value until the next read on that port.
- Requesters hold `req`, `adr`, `we` and `wd` stable until they see `gnt`. The transaction completes at the edge where `gnt` is high. Dropping `req` before `gnt` cancels the request with no side effects.
- Read-after-write:
  - A data write granted in cycle N is visible to any read granted in cycle N+1 or later.
  - No forwarding is needed, because the memory writes at the edge and reads combinationally.

## Timing
- Reset values (rst high at an edge):
  - `last` = 1, so the first tie goes to fetch.
  - `if_rdata` = `d_rdata` = 0; `if_rvalid` = `d_rvalid` = 0.
- While `rst` is high:
  - `if_gnt` = `d_gnt` = 0.
  - `mem_we` = 0, `mem_adr` = 0, `mem_wd` = 0.
  - No memory write occurs.
- Reset asserted in the cycle after a granted read clears the pending rvalid; that read result is discarded.
- Grant latency: 0 cycles (`gnt` is in the same cycle as `req` when the port wins).
- Read latency: `rvalid`/`rdata` appear 1 cycle after the `gnt` cycle.
- Throughput:
  - 1 access per cycle total.
  - Under continuous contention the ports alternate, so each port gets 1 access per 2 cycles.
  - Maximum wait for a held request is 1 cycle.
- Back-to-back reads on one port (no contention): `rvalid` stays high on consecutive cycles and `rdata` updates each cycle.

## Test plan
- Reset, then idle with both reqs low:
  - All outputs are 0.
  - `mem_we` stays 0 for 5 cycles.
- Data write 0xA5A5 to adr 0, then data write 0x5A5A to adr 1, then fetch reads adr 0 and adr 1:
  - `d_gnt` is high each write cycle and `d_rvalid` never asserts.
  - `if_rvalid` pulses with `if_rdata` = 0xA5A5, then 0x5A5A.
- Both ports request reads (fetch adr 2, data adr 3) held for 4 cycles after reset:
  - Grants go fetch, data, fetch, data.
  - `mem_adr` sequence is 2, 3, 2, 3.
- Data write 0x1234 to adr 4 in cycle N, fetch read of adr 4 requested in cycle N and held:
  - If fetch wins cycle N (last = 1), `if_rdata` = old value.
  - If data wins, fetch is granted in N+1 and `if_rdata` = 0x1234 in N+2.
- Fetch read granted, `rst` asserted the next cycle:
  - `if_rvalid` = 0 and `if_rdata` = 0 after the reset edge.
  - The first post-reset tie grants fetch.
- Data port raises `d_req` with `d_we` = 1, then drops it before grant while fetch holds the port:
  - Memory is unchanged at that address.
  - `d_gnt` never asserts.
